// File: rtl/idc_index_bank.sv
// Bank of NUM_CH modulo index counters for the down-sampling datapath.
// One channel (or all, for broadcast clear) is updated per cycle from the instruction select field.
module idc_index_bank #(
    parameter int WIDTH      = 8,
    parameter int NUM_CH     = 4,
    parameter int INSTR_W    = 16,
    parameter int SEL_MSB    = 11,
    parameter int SEL_LSB    = 8,
    parameter int SEL_BASE   = 9,
    parameter int BCAST_CODE = 15
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [2:0]                idc_op,
    input  logic [INSTR_W-1:0]        instruction,
    input  logic [WIDTH-1:0]          load_value,
    output logic [NUM_CH*WIDTH-1:0]   idx_flat,
    output logic [NUM_CH-1:0]         wrap_pulse,
    output logic [NUM_CH-1:0]         at_limit,
    output logic [NUM_CH-1:0]         at_zero,
    output logic                      op_err
);

    localparam int SW = SEL_MSB - SEL_LSB + 1;
    localparam logic [SW-1:0] SEL_BASE_C = SW'(SEL_BASE);
    localparam logic [SW-1:0] SEL_TOP_C  = SW'(SEL_BASE + NUM_CH - 1);
    localparam logic [SW-1:0] BCAST_C    = SW'(BCAST_CODE);

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_DEC    = 3'b010;
    localparam logic [2:0] OP_CLEAR  = 3'b011;
    localparam logic [2:0] OP_LOAD   = 3'b100;
    localparam logic [2:0] OP_SETLIM = 3'b101;
    localparam logic [2:0] OP_STEP   = 3'b110;
    localparam logic [2:0] OP_RSVD   = 3'b111;

    logic [WIDTH-1:0] idx_r    [NUM_CH];
    logic [WIDTH-1:0] lim_r    [NUM_CH];
    logic [WIDTH-1:0] idx_nxt_s[NUM_CH];
    logic [WIDTH-1:0] lim_nxt_s[NUM_CH];
    logic [WIDTH:0]   sum_s    [NUM_CH];
    logic [NUM_CH-1:0] wrap_nxt_s;
    logic [NUM_CH-1:0] wrap_r;
    logic              op_err_r;

    logic [SW-1:0] field_s;
    logic [SW-1:0] sel_idx_s;
    logic          sel_valid_s;
    logic          is_hold_s;
    logic          bcast_clr_s;
    logic          err_nxt_s;

    assign field_s     = instruction[SEL_MSB:SEL_LSB];
    assign sel_valid_s = (field_s >= SEL_BASE_C) && (field_s <= SEL_TOP_C);
    assign sel_idx_s   = field_s - SEL_BASE_C;
    assign is_hold_s   = (idc_op == OP_HOLD) || (idc_op == OP_RSVD);
    assign bcast_clr_s = (field_s == BCAST_C) && (idc_op == OP_CLEAR);
    assign err_nxt_s   = !is_hold_s && !sel_valid_s && !bcast_clr_s;

    // Next-state computation for every channel; only the selected one changes.
    always_comb begin
        wrap_nxt_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx_nxt_s[k] = idx_r[k];
            lim_nxt_s[k] = lim_r[k];
            sum_s[k]     = {1'b0, idx_r[k]} + {1'b0, load_value};
            if (bcast_clr_s) begin
                idx_nxt_s[k] = '0;
            end else if (sel_valid_s && (sel_idx_s == SW'(k))) begin
                case (idc_op)
                    OP_INC: begin
                        if (idx_r[k] == lim_r[k]) begin
                            idx_nxt_s[k]  = '0;
                            wrap_nxt_s[k] = 1'b1;
                        end else begin
                            idx_nxt_s[k] = idx_r[k] + WIDTH'(1);
                        end
                    end
                    OP_DEC: begin
                        if (idx_r[k] == '0) begin
                            idx_nxt_s[k]  = lim_r[k];
                            wrap_nxt_s[k] = 1'b1;
                        end else begin
                            idx_nxt_s[k] = idx_r[k] - WIDTH'(1);
                        end
                    end
                    OP_CLEAR:  idx_nxt_s[k] = '0;
                    OP_LOAD:   idx_nxt_s[k] = load_value;
                    OP_SETLIM: lim_nxt_s[k] = load_value;
                    OP_STEP: begin
                        // lim+1 is formed in WIDTH+1 bits so an all-ones limit wraps at 2^WIDTH.
                        if (sum_s[k] > {1'b0, lim_r[k]}) begin
                            idx_nxt_s[k]  = WIDTH'(sum_s[k] - ({1'b0, lim_r[k]} + (WIDTH+1)'(1)));
                            wrap_nxt_s[k] = 1'b1;
                        end else begin
                            idx_nxt_s[k] = sum_s[k][WIDTH-1:0];
                        end
                    end
                    default: begin
                        idx_nxt_s[k] = idx_r[k];
                    end
                endcase
            end else begin
                idx_nxt_s[k] = idx_r[k];
            end
        end
    end

    // Counter, limit and pulse registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx_r[k] <= '0;
                lim_r[k] <= '1;
            end
            wrap_r   <= '0;
            op_err_r <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx_r[k] <= idx_nxt_s[k];
                lim_r[k] <= lim_nxt_s[k];
            end
            wrap_r   <= wrap_nxt_s;
            op_err_r <= err_nxt_s;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign idx_flat[g*WIDTH +: WIDTH] = idx_r[g];
        assign at_limit[g]                = (idx_r[g] == lim_r[g]);
        assign at_zero[g]                 = (idx_r[g] == '0);
    end

    assign wrap_pulse = wrap_r;
    assign op_err     = op_err_r;

endmodule

// File: tb/tb_idc_index_bank.sv
// Directed self-checking bench for idc_index_bank with the default four 8-bit channels.
module tb_idc_index_bank;

    logic        clock;
    logic        resetn;
    logic [2:0]  idc_op;
    logic [15:0] instruction;
    logic [7:0]  load_value;
    logic [31:0] idx_flat;
    logic [3:0]  wrap_pulse;
    logic [3:0]  at_limit;
    logic [3:0]  at_zero;
    logic        op_err;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    idc_index_bank dut (
        .clock       (clock),
        .resetn      (resetn),
        .idc_op      (idc_op),
        .instruction (instruction),
        .load_value  (load_value),
        .idx_flat    (idx_flat),
        .wrap_pulse  (wrap_pulse),
        .at_limit    (at_limit),
        .at_zero     (at_zero),
        .op_err      (op_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [3:0] field, input logic [7:0] lv);
        idc_op      = op;
        instruction = {4'h0, field, 8'h00};
        load_value  = lv;
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn      = 1'b0;
        idc_op      = 3'b000;
        instruction = 16'h0000;
        load_value  = 8'h00;
        #12;
        chk("rst_idx", idx_flat, 32'h0);
        chk("rst_wrap", wrap_pulse, 4'b0000);
        chk("rst_err", op_err, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("rel_zero", at_zero, 4'b1111);
        chk("rel_limit", at_limit, 4'b0000);

        // Reset in the middle of an INC run clears without a clock edge.
        do_op(3'b001, 4'b1001, 8'h00);
        do_op(3'b001, 4'b1001, 8'h00);
        chk("mid_pre", idx_flat, 32'h00000002);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst", idx_flat, 32'h0);
        idc_op = 3'b000;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_after", idx_flat, 32'h0);

        // ch0 INC x3
        do_op(3'b001, 4'b1001, 8'h00);
        do_op(3'b001, 4'b1001, 8'h00);
        do_op(3'b001, 4'b1001, 8'h00);
        chk("inc3_idx", idx_flat, 32'h00000003);
        chk("inc3_wrap", wrap_pulse, 4'b0000);

        // ch1 DEC from 0 wraps to the all-ones limit for one cycle
        do_op(3'b010, 4'b1010, 8'h00);
        chk("dec_idx", idx_flat, 32'h0000FF03);
        chk("dec_wrap", wrap_pulse, 4'b0010);
        do_op(3'b000, 4'b1010, 8'h00);
        chk("dec_wrap_drop", wrap_pulse, 4'b0000);

        // ch2 limit 4, INC x5 -> 1,2,3,4,0
        do_op(3'b101, 4'b1011, 8'd4);
        do_op(3'b011, 4'b1011, 8'd0);
        do_op(3'b001, 4'b1011, 8'd0);
        chk("ch2_1", idx_flat[23:16], 8'd1);
        chk("ch2_1w", wrap_pulse, 4'b0000);
        do_op(3'b001, 4'b1011, 8'd0);
        chk("ch2_2", idx_flat[23:16], 8'd2);
        do_op(3'b001, 4'b1011, 8'd0);
        chk("ch2_3", idx_flat[23:16], 8'd3);
        chk("ch2_3lim", at_limit[2], 1'b0);
        do_op(3'b001, 4'b1011, 8'd0);
        chk("ch2_4", idx_flat[23:16], 8'd4);
        chk("ch2_4lim", at_limit[2], 1'b1);
        chk("ch2_4w", wrap_pulse, 4'b0000);
        do_op(3'b001, 4'b1011, 8'd0);
        chk("ch2_0", idx_flat[23:16], 8'd0);
        chk("ch2_0w", wrap_pulse, 4'b0100);

        // ch3 STEP with wrap, then without
        do_op(3'b101, 4'b1100, 8'd9);
        do_op(3'b100, 4'b1100, 8'd7);
        do_op(3'b110, 4'b1100, 8'd5);
        chk("step_wrap_idx", idx_flat[31:24], 8'd2);
        chk("step_wrap_w", wrap_pulse, 4'b1000);
        do_op(3'b110, 4'b1100, 8'd2);
        chk("step_idx", idx_flat[31:24], 8'd4);
        chk("step_w", wrap_pulse, 4'b0000);

        // Broadcast clear: all nonzero before, all zero after, limits kept
        do_op(3'b100, 4'b1011, 8'd5);
        chk("pre_bcast", idx_flat, 32'h0405FF03);
        do_op(3'b011, 4'b1111, 8'd0);
        chk("bcast_idx", idx_flat, 32'h0);
        chk("bcast_err", op_err, 1'b0);
        do_op(3'b010, 4'b1011, 8'd0);
        do_op(3'b010, 4'b1100, 8'd0);
        chk("lim_kept", idx_flat, 32'h09040000);
        chk("lim_kept_w", wrap_pulse, 4'b1000);

        // Broadcast code with INC is an error and changes nothing
        do_op(3'b001, 4'b1111, 8'd0);
        chk("bmis_idx", idx_flat, 32'h09040000);
        chk("bmis_err", op_err, 1'b1);
        chk("bmis_w", wrap_pulse, 4'b0000);
        do_op(3'b000, 4'b1111, 8'd0);
        chk("bmis_err_drop", op_err, 1'b0);

        // Out-of-range select
        do_op(3'b001, 4'b0010, 8'd0);
        chk("inv_idx", idx_flat, 32'h09040000);
        chk("inv_err", op_err, 1'b1);
        do_op(3'b000, 4'b0010, 8'd0);
        chk("inv_hold_err", op_err, 1'b0);

        // lim = 0: INC and DEC stay at 0 and wrap every cycle
        do_op(3'b101, 4'b1001, 8'd0);
        do_op(3'b001, 4'b1001, 8'd0);
        chk("l0_inc1", idx_flat[7:0], 8'd0);
        chk("l0_inc1w", wrap_pulse, 4'b0001);
        do_op(3'b001, 4'b1001, 8'd0);
        chk("l0_inc2w", wrap_pulse, 4'b0001);
        do_op(3'b010, 4'b1001, 8'd0);
        chk("l0_dec", idx_flat, 32'h09040000);
        chk("l0_decw", wrap_pulse, 4'b0001);
        do_op(3'b111, 4'b1001, 8'd0);
        chk("rsvd_w", wrap_pulse, 4'b0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
